// File: rtl/pipe_controller_ext.sv
// pipe_controller_ext: RV32I pipelined control unit.
// Decodes opcode/funct3/funct7b5 in Decode and carries the control bundle
// through the Execute, Memory and Writeback stages. Execute resolves branches
// from the ALU flags. The E register can be stalled or flushed, and a valid
// bit travels with every instruction.
// Optional feature: define PIPE_CTRL_PERF_CNT_EN to add retire and taken
// counters (RetireCnt, TakenCnt).

module pipe_controller_ext #(
    parameter int ALUCTRL_W = 4,
    parameter int IMMSRC_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic                 funct7b5D,
    input  logic                 ValidD,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [IMMSRC_W-1:0]  ImmSrcD,
    output logic                 IllegalD,
    output logic                 PCSrcE,
    output logic                 PCTgtSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [1:0]           ALUSrcAE,
    output logic                 ALUSrcBE,
    output logic                 ResultSrcE0,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW,
    output logic                 ValidW
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]          RetireCnt,
    output logic [31:0]          TakenCnt
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Decode-stage control signals
    logic                 w_regWriteD;
    logic [1:0]           w_resultSrcD;
    logic                 w_memWriteD;
    logic                 w_jumpD;
    logic                 w_jalrD;
    logic                 w_branchD;
    logic [3:0]           w_aluOpD;
    logic [3:0]           w_funcAluD;
    logic [1:0]           w_aluSrcAD;
    logic                 w_aluSrcBD;
    logic [2:0]           w_immSelD;
    logic                 w_legalD;
    logic [ALUCTRL_W-1:0] w_aluControlD;

    // Execute-stage registers
    logic                 r_regWriteE;
    logic [1:0]           r_resultSrcE;
    logic                 r_memWriteE;
    logic                 r_jumpE;
    logic                 r_jalrE;
    logic                 r_branchE;
    logic [2:0]           r_funct3E;
    logic [ALUCTRL_W-1:0] r_aluControlE;
    logic [1:0]           r_aluSrcAE;
    logic                 r_aluSrcBE;
    logic                 r_validE;
    logic                 w_takenE;

    // Memory-stage registers
    logic                 r_regWriteM;
    logic [1:0]           r_resultSrcM;
    logic                 r_memWriteM;
    logic                 r_validM;

    // Writeback-stage registers
    logic                 r_regWriteW;
    logic [1:0]           r_resultSrcW;
    logic                 r_validW;

    // Arithmetic operation selected by funct3; sub only exists for R-type, sra for both
    always_comb begin
        w_funcAluD = ALU_ADD;
        case (funct3D)
            3'b000:  w_funcAluD = ((opD == OP_RTYPE) && funct7b5D) ? ALU_SUB : ALU_ADD;
            3'b001:  w_funcAluD = ALU_SLL;
            3'b010:  w_funcAluD = ALU_SLT;
            3'b011:  w_funcAluD = ALU_SLTU;
            3'b100:  w_funcAluD = ALU_XOR;
            3'b101:  w_funcAluD = funct7b5D ? ALU_SRA : ALU_SRL;
            3'b110:  w_funcAluD = ALU_OR;
            default: w_funcAluD = ALU_AND;
        endcase
    end

    // Main opcode decoder; unknown opcodes leave every write/branch/jump control at 0
    always_comb begin
        w_regWriteD  = 1'b0;
        w_resultSrcD = 2'b00;
        w_memWriteD  = 1'b0;
        w_jumpD      = 1'b0;
        w_jalrD      = 1'b0;
        w_branchD    = 1'b0;
        w_aluOpD     = ALU_ADD;
        w_aluSrcAD   = 2'b00;
        w_aluSrcBD   = 1'b0;
        w_immSelD    = IMM_I;
        w_legalD     = 1'b1;
        case (opD)
            OP_LOAD: begin
                w_regWriteD  = 1'b1;
                w_aluSrcBD   = 1'b1;
                w_resultSrcD = 2'b01;
            end
            OP_STORE: begin
                w_memWriteD = 1'b1;
                w_immSelD   = IMM_S;
                w_aluSrcBD  = 1'b1;
            end
            OP_RTYPE: begin
                w_regWriteD = 1'b1;
                w_aluOpD    = w_funcAluD;
            end
            OP_IALU: begin
                w_regWriteD = 1'b1;
                w_aluOpD    = w_funcAluD;
                w_aluSrcBD  = 1'b1;
            end
            OP_BRANCH: begin
                w_branchD = 1'b1;
                w_immSelD = IMM_B;
                w_aluOpD  = ALU_SUB;
            end
            OP_JAL: begin
                w_jumpD      = 1'b1;
                w_regWriteD  = 1'b1;
                w_resultSrcD = 2'b10;
                w_immSelD    = IMM_J;
            end
            OP_JALR: begin
                w_jumpD      = 1'b1;
                w_jalrD      = 1'b1;
                w_regWriteD  = 1'b1;
                w_resultSrcD = 2'b10;
                w_aluSrcBD   = 1'b1;
            end
            OP_LUI: begin
                w_aluSrcAD  = 2'b10;
                w_aluSrcBD  = 1'b1;
                w_immSelD   = IMM_U;
                w_regWriteD = 1'b1;
            end
            OP_AUIPC: begin
                w_aluSrcAD  = 2'b01;
                w_aluSrcBD  = 1'b1;
                w_immSelD   = IMM_U;
                w_regWriteD = 1'b1;
            end
            default: begin
                w_legalD = 1'b0;
            end
        endcase
    end

    // Widen the ALU code and immediate select to their parameter widths, upper bits zero
    always_comb begin
        w_aluControlD      = '0;
        w_aluControlD[3:0] = w_aluOpD;
        ImmSrcD            = '0;
        ImmSrcD[2:0]       = w_immSelD;
    end

    assign IllegalD = ValidD & ~w_legalD;

    // D->E register: reset, then flush (bubble), then stall (hold), else load
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            r_regWriteE   <= 1'b0;
            r_resultSrcE  <= 2'b00;
            r_memWriteE   <= 1'b0;
            r_jumpE       <= 1'b0;
            r_jalrE       <= 1'b0;
            r_branchE     <= 1'b0;
            r_funct3E     <= 3'b000;
            r_aluControlE <= '0;
            r_aluSrcAE    <= 2'b00;
            r_aluSrcBE    <= 1'b0;
            r_validE      <= 1'b0;
        end else if (!StallE) begin
            r_regWriteE   <= w_regWriteD;
            r_resultSrcE  <= w_resultSrcD;
            r_memWriteE   <= w_memWriteD;
            r_jumpE       <= w_jumpD;
            r_jalrE       <= w_jalrD;
            r_branchE     <= w_branchD;
            r_funct3E     <= funct3D;
            r_aluControlE <= w_aluControlD;
            r_aluSrcAE    <= w_aluSrcAD;
            r_aluSrcBE    <= w_aluSrcBD;
            r_validE      <= ValidD;
        end
    end

    // Branch condition chosen by funct3 from the ALU comparison flags
    always_comb begin
        w_takenE = 1'b0;
        case (r_funct3E)
            3'b000:  w_takenE = ZeroE;
            3'b001:  w_takenE = ~ZeroE;
            3'b100:  w_takenE = LtE;
            3'b101:  w_takenE = ~LtE;
            3'b110:  w_takenE = LtuE;
            3'b111:  w_takenE = ~LtuE;
            default: w_takenE = 1'b0;
        endcase
    end

    assign PCSrcE      = (r_branchE & w_takenE) | r_jumpE;
    assign PCTgtSrcE   = r_jalrE;
    assign ALUControlE = r_aluControlE;
    assign ALUSrcAE    = r_aluSrcAE;
    assign ALUSrcBE    = r_aluSrcBE;
    assign ResultSrcE0 = r_resultSrcE[0];

    // E->M register; side-effecting controls are masked by the valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regWriteM  <= 1'b0;
            r_resultSrcM <= 2'b00;
            r_memWriteM  <= 1'b0;
            r_validM     <= 1'b0;
        end else begin
            r_regWriteM  <= r_regWriteE & r_validE;
            r_resultSrcM <= r_resultSrcE & {2{r_validE}};
            r_memWriteM  <= r_memWriteE & r_validE;
            r_validM     <= r_validE;
        end
    end

    // M->W register; same masking so bubbles never write the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regWriteW  <= 1'b0;
            r_resultSrcW <= 2'b00;
            r_validW     <= 1'b0;
        end else begin
            r_regWriteW  <= r_regWriteM & r_validM;
            r_resultSrcW <= r_resultSrcM & {2{r_validM}};
            r_validW     <= r_validM;
        end
    end

    assign MemWriteM  = r_memWriteM;
    assign RegWriteM  = r_regWriteM;
    assign RegWriteW  = r_regWriteW;
    assign ResultSrcW = r_resultSrcW;
    assign ValidW     = r_validW;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] r_retireCnt;
    logic [31:0] r_takenCnt;

    // Free-running performance counters; they wrap and ignore stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retireCnt <= 32'd0;
            r_takenCnt  <= 32'd0;
        end else begin
            if (r_validW) begin
                r_retireCnt <= r_retireCnt + 32'd1;
            end
            if (PCSrcE && r_validE) begin
                r_takenCnt <= r_takenCnt + 32'd1;
            end
        end
    end

    assign RetireCnt = r_retireCnt;
    assign TakenCnt  = r_takenCnt;
`endif

endmodule

// File: tb/tb_pipe_controller_ext.sv
// Testbench for pipe_controller_ext: a table of decode vectors streamed
// through the pipeline with a per-stage scoreboard, plus hand-written
// sequences for reset, stall/flush and (with PIPE_CTRL_PERF_CNT_EN) counters.

module tb_pipe_controller_ext;

    logic        clk;
    logic        rst;
    logic [6:0]  opD;
    logic [2:0]  funct3D;
    logic        funct7b5D;
    logic        ValidD;
    logic        StallE;
    logic        FlushE;
    logic        ZeroE;
    logic        LtE;
    logic        LtuE;
    logic [2:0]  ImmSrcD;
    logic        IllegalD;
    logic        PCSrcE;
    logic        PCTgtSrcE;
    logic [3:0]  ALUControlE;
    logic [1:0]  ALUSrcAE;
    logic        ALUSrcBE;
    logic        ResultSrcE0;
    logic        MemWriteM;
    logic        RegWriteM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        ValidW;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] RetireCnt;
    logic [31:0] TakenCnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    pipe_controller_ext #(.ALUCTRL_W(4), .IMMSRC_W(3)) dut (
        .clk(clk), .rst(rst), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE),
        .LtuE(LtuE), .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .PCSrcE(PCSrcE),
        .PCTgtSrcE(PCTgtSrcE), .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE),
        .ALUSrcBE(ALUSrcBE), .ResultSrcE0(ResultSrcE0), .MemWriteM(MemWriteM),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ValidW(ValidW)
`ifdef PIPE_CTRL_PERF_CNT_EN
        , .RetireCnt(RetireCnt), .TakenCnt(TakenCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       valid;
        logic       zero;
        logic       lt;
        logic       ltu;
        logic [2:0] imm;
        logic       ill;
        logic [3:0] alu;
        logic       pc;
        logic       tgt;
        logic [1:0] srcA;
        logic       srcB;
        logic       rsE0;
        logic       memW;
        logic       regW;
        logic [1:0] resW;
    } vec_t;

    vec_t vecs[$];
    vec_t qE[$];
    vec_t qM[$];
    vec_t qW[$];

    function automatic vec_t mk(
        input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic valid,
        input logic zero, input logic lt, input logic ltu,
        input logic [2:0] imm, input logic ill, input logic [3:0] alu,
        input logic pc, input logic tgt, input logic [1:0] srcA, input logic srcB,
        input logic rsE0, input logic memW, input logic regW, input logic [1:0] resW);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.valid = valid;
        v.zero = zero; v.lt = lt; v.ltu = ltu;
        v.imm = imm; v.ill = ill; v.alu = alu; v.pc = pc; v.tgt = tgt;
        v.srcA = srcA; v.srcB = srcB; v.rsE0 = rsE0; v.memW = memW;
        v.regW = regW; v.resW = resW;
        return v;
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, input logic valid);
        opD       = op;
        funct3D   = f3;
        funct7b5D = f7;
        ValidD    = valid;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".PCSrcE"},      32'(PCSrcE),      32'd0);
        checkOutput({tag, ".PCTgtSrcE"},   32'(PCTgtSrcE),   32'd0);
        checkOutput({tag, ".ALUControlE"}, 32'(ALUControlE), 32'd0);
        checkOutput({tag, ".ALUSrcAE"},    32'(ALUSrcAE),    32'd0);
        checkOutput({tag, ".ALUSrcBE"},    32'(ALUSrcBE),    32'd0);
        checkOutput({tag, ".ResultSrcE0"}, 32'(ResultSrcE0), 32'd0);
        checkOutput({tag, ".MemWriteM"},   32'(MemWriteM),   32'd0);
        checkOutput({tag, ".RegWriteM"},   32'(RegWriteM),   32'd0);
        checkOutput({tag, ".RegWriteW"},   32'(RegWriteW),   32'd0);
        checkOutput({tag, ".ResultSrcW"},  32'(ResultSrcW),  32'd0);
        checkOutput({tag, ".ValidW"},      32'(ValidW),      32'd0);
    endtask

    initial begin
        vec_t v;
        int   nv;

        // op, f3, f7, valid, zero, lt, ltu | imm, ill, alu, pc, tgt, srcA, srcB, rsE0, memW, regW, resW
        vecs.push_back(mk(7'b0110011, 3'b000, 0, 1, 0, 0, 0, 3'b000, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00)); // add
        vecs.push_back(mk(7'b0110011, 3'b000, 1, 1, 0, 0, 0, 3'b000, 0, 4'b0001, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00)); // sub
        vecs.push_back(mk(7'b0010011, 3'b000, 1, 1, 0, 0, 0, 3'b000, 0, 4'b0000, 0, 0, 2'b00, 1, 0, 0, 1, 2'b00)); // addi f7b5=1
        vecs.push_back(mk(7'b0010011, 3'b101, 1, 1, 0, 0, 0, 3'b000, 0, 4'b1001, 0, 0, 2'b00, 1, 0, 0, 1, 2'b00)); // srai
        vecs.push_back(mk(7'b0110011, 3'b101, 0, 1, 0, 0, 0, 3'b000, 0, 4'b1000, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00)); // srl
        vecs.push_back(mk(7'b0110011, 3'b111, 0, 1, 0, 0, 0, 3'b000, 0, 4'b0010, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00)); // and
        vecs.push_back(mk(7'b0110011, 3'b110, 0, 1, 0, 0, 0, 3'b000, 0, 4'b0011, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00)); // or
        vecs.push_back(mk(7'b0010011, 3'b100, 0, 1, 0, 0, 0, 3'b000, 0, 4'b0100, 0, 0, 2'b00, 1, 0, 0, 1, 2'b00)); // xori
        vecs.push_back(mk(7'b0110011, 3'b010, 0, 1, 0, 0, 0, 3'b000, 0, 4'b0101, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00)); // slt
        vecs.push_back(mk(7'b0110011, 3'b011, 0, 1, 0, 0, 0, 3'b000, 0, 4'b0110, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00)); // sltu
        vecs.push_back(mk(7'b0010011, 3'b001, 0, 1, 0, 0, 0, 3'b000, 0, 4'b0111, 0, 0, 2'b00, 1, 0, 0, 1, 2'b00)); // slli
        vecs.push_back(mk(7'b0000011, 3'b010, 0, 1, 0, 0, 0, 3'b000, 0, 4'b0000, 0, 0, 2'b00, 1, 1, 0, 1, 2'b01)); // lw
        vecs.push_back(mk(7'b0100011, 3'b010, 0, 1, 0, 0, 0, 3'b001, 0, 4'b0000, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00)); // sw
        vecs.push_back(mk(7'b1100011, 3'b000, 0, 1, 1, 0, 0, 3'b010, 0, 4'b0001, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00)); // beq taken
        vecs.push_back(mk(7'b1100011, 3'b001, 0, 1, 0, 0, 0, 3'b010, 0, 4'b0001, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00)); // bne Z=0
        vecs.push_back(mk(7'b1100011, 3'b101, 0, 1, 0, 1, 0, 3'b010, 0, 4'b0001, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00)); // bge Lt=1
        vecs.push_back(mk(7'b1100011, 3'b110, 0, 1, 0, 0, 1, 3'b010, 0, 4'b0001, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00)); // bltu Ltu=1
        vecs.push_back(mk(7'b1100011, 3'b010, 0, 1, 1, 1, 1, 3'b010, 0, 4'b0001, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00)); // f3=010
        vecs.push_back(mk(7'b1100011, 3'b100, 0, 1, 1, 0, 1, 3'b010, 0, 4'b0001, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00)); // blt Lt=0
        vecs.push_back(mk(7'b1100011, 3'b111, 0, 1, 0, 1, 0, 3'b010, 0, 4'b0001, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00)); // bgeu Ltu=0
        vecs.push_back(mk(7'b1101111, 3'b000, 0, 1, 0, 0, 0, 3'b011, 0, 4'b0000, 1, 0, 2'b00, 0, 0, 0, 1, 2'b10)); // jal
        vecs.push_back(mk(7'b1100111, 3'b000, 0, 1, 0, 0, 0, 3'b000, 0, 4'b0000, 1, 1, 2'b00, 1, 0, 0, 1, 2'b10)); // jalr
        vecs.push_back(mk(7'b0110111, 3'b000, 0, 1, 0, 0, 0, 3'b100, 0, 4'b0000, 0, 0, 2'b10, 1, 0, 0, 1, 2'b00)); // lui
        vecs.push_back(mk(7'b0010111, 3'b000, 0, 1, 0, 0, 0, 3'b100, 0, 4'b0000, 0, 0, 2'b01, 1, 0, 0, 1, 2'b00)); // auipc
        vecs.push_back(mk(7'b1111111, 3'b000, 0, 1, 0, 0, 0, 3'b000, 1, 4'b0000, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00)); // illegal
        vecs.push_back(mk(7'b1111111, 3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00)); // illegal, invalid
        vecs.push_back(mk(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00)); // add, invalid
        vecs.push_back(mk(7'b0100011, 3'b010, 0, 0, 0, 0, 0, 3'b001, 0, 4'b0000, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00)); // sw, invalid
        nv = vecs.size();

        // Reset held two cycles with a valid R-type sitting in Decode
        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
        applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checkAllZero("reset");

        // First R-type after release reaches RegWriteW three edges later
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("post_reset.RegWriteW[c%0d]", c), 32'(RegWriteW), (c == 3) ? 32'd1 : 32'd0);
        end
        repeat (2) @(negedge clk);

        // Table stream with per-stage scoreboard
        for (int t = 0; t < nv + 3; t++) begin
            @(negedge clk);
            if (t < nv) applyStimulus(vecs[t].op, vecs[t].f3, vecs[t].f7, vecs[t].valid);
            else        applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0);
            if (t >= 1 && t <= nv) begin
                ZeroE = vecs[t-1].zero; LtE = vecs[t-1].lt; LtuE = vecs[t-1].ltu;
            end else begin
                ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
            end
            #1;
            if (qW.size() > 0) begin
                v = qW.pop_front();
                checkOutput($sformatf("W.RegWriteW[%0d]", t - 3),  32'(RegWriteW),  32'(v.regW & v.valid));
                checkOutput($sformatf("W.ResultSrcW[%0d]", t - 3), 32'(ResultSrcW), 32'(v.resW & {2{v.valid}}));
                checkOutput($sformatf("W.ValidW[%0d]", t - 3),     32'(ValidW),     32'(v.valid));
            end
            if (qM.size() > 0) begin
                v = qM.pop_front();
                checkOutput($sformatf("M.MemWriteM[%0d]", t - 2), 32'(MemWriteM), 32'(v.memW & v.valid));
                checkOutput($sformatf("M.RegWriteM[%0d]", t - 2), 32'(RegWriteM), 32'(v.regW & v.valid));
                qW.push_back(v);
            end
            if (qE.size() > 0) begin
                v = qE.pop_front();
                checkOutput($sformatf("E.ALUControlE[%0d]", t - 1), 32'(ALUControlE), 32'(v.alu));
                checkOutput($sformatf("E.PCSrcE[%0d]", t - 1),      32'(PCSrcE),      32'(v.pc));
                checkOutput($sformatf("E.PCTgtSrcE[%0d]", t - 1),   32'(PCTgtSrcE),   32'(v.tgt));
                checkOutput($sformatf("E.ALUSrcAE[%0d]", t - 1),    32'(ALUSrcAE),    32'(v.srcA));
                checkOutput($sformatf("E.ALUSrcBE[%0d]", t - 1),    32'(ALUSrcBE),    32'(v.srcB));
                checkOutput($sformatf("E.ResultSrcE0[%0d]", t - 1), 32'(ResultSrcE0), 32'(v.rsE0));
                qM.push_back(v);
            end
            if (t < nv) begin
                checkOutput($sformatf("D.ImmSrcD[%0d]", t),  32'(ImmSrcD),  32'(vecs[t].imm));
                checkOutput($sformatf("D.IllegalD[%0d]", t), 32'(IllegalD), 32'(vecs[t].ill));
                qE.push_back(vecs[t]);
            end
        end

        // Stall: sub in E, lw waits in Decode for two stalled cycles
        @(negedge clk);
        applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b1);
        StallE = 1'b1;
        #1;
        checkOutput("stall.ALUControlE[c0]", 32'(ALUControlE), 32'd1);
        checkOutput("stall.ResultSrcE0[c0]", 32'(ResultSrcE0), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); #1;
            checkOutput($sformatf("stall.ALUControlE[c%0d]", c), 32'(ALUControlE), 32'd1);
            checkOutput($sformatf("stall.ResultSrcE0[c%0d]", c), 32'(ResultSrcE0), 32'd0);
        end
        StallE = 1'b0;
        @(negedge clk); #1;
        checkOutput("stall.release.ResultSrcE0", 32'(ResultSrcE0), 32'd1);
        checkOutput("stall.release.ALUControlE", 32'(ALUControlE), 32'd0);

        // Flush and stall together: flush wins, E becomes a bubble
        FlushE = 1'b1; StallE = 1'b1;
        @(negedge clk); #1;
        checkOutput("flush.ResultSrcE0", 32'(ResultSrcE0), 32'd0);
        checkOutput("flush.ALUSrcBE",    32'(ALUSrcBE),    32'd0);
        checkOutput("flush.RegWriteM_lw", 32'(RegWriteM),  32'd1);
        FlushE = 1'b0; StallE = 1'b0;
        applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkOutput("flush.RegWriteM_bubble", 32'(RegWriteM), 32'd0);

        // Reset in the middle of a jal discards it
        applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b1);
        @(negedge clk); #1;
        checkOutput("midreset.PCSrcE_before", 32'(PCSrcE), 32'd1);
        rst = 1'b1;
        applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkAllZero("midreset");
        rst = 1'b0;

`ifdef PIPE_CTRL_PERF_CNT_EN
        // Counters: five valid adds then one valid jal
        checkOutput("perf.RetireCnt_reset", RetireCnt, 32'd0);
        checkOutput("perf.TakenCnt_reset",  TakenCnt,  32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b1);
        end
        @(negedge clk);
        applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkOutput("perf.TakenCnt", TakenCnt, 32'd1);
        repeat (1) @(negedge clk);
        #1;
        checkOutput("perf.RetireCnt_adds", RetireCnt, 32'd5);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("perf.RetireCnt_all", RetireCnt, 32'd6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
